mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
// MEM stage of the rv32i pipeline. Sits between the EX/MEM and MEM/WB buffers.
// Issues load/store requests to the data cache via a read/write/resp handshake and generates byte enables.
// Aligns and sign-extends load data, stalls the pipeline while a request is outstanding, and registers the MEM/WB result.
// PARAMETERS
// MAX_WAIT  256  cycles in WAIT before timeout_err sets (sticky); legal range 2..65535
// PORTS
// clk             in   1   clock; all state updates on posedge
// rst             in   1   synchronous reset, active-low (asserted when rst==0)
// in_valid        in   1   EX/MEM entry holds a real instruction
// in_is_load      in   1   instruction is a load
// in_is_store     in   1   instruction is a store
// in_funct3       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
// in_addr         in   32  byte address (mar)
// in_store_data   in   32  rs2 data, already shifted by 8*addr[1:0]
// in_alu_data     in   32  writeback value for non-load instructions
// in_rd           in   5   destination register
// in_load_regfile in   1   instruction writes rd
// dmem_read       out  1   read request
// dmem_write      out  1   write request
// dmem_address    out  32  {addr[31:2],2'b00}
// dmem_wdata      out  32  store data
// dmem_mbe        out  4   byte enables
// dmem_rdata      in   32  read data, valid when dmem_resp==1
// dmem_resp       in   1   single-cycle completion pulse
// stall           out  1   freeze PC, IF/ID, ID/EX, EX/MEM this cycle
// wb_valid        out  1   MEM/WB entry valid
// wb_rd           out  5   MEM/WB rd
// wb_load_regfile out  1   MEM/WB regfile write enable; also the forwarding enable
// wb_data         out  32  MEM/WB rd data; also mem_wb forwarding data
// misaligned_err  out  1   one-cycle pulse: misaligned access was dropped
// timeout_err     out  1   sticky flag: request exceeded MAX_WAIT
// BEHAVIOUR
// - Reset: state=IDLE, wait counter=0. All registered outputs 0. dmem_read/write=0, stall=0.
// - mem_op = in_valid & (in_is_load | in_is_store) & ~misaligned.
// - misaligned: H/HU when addr[0]==1; W when addr[1:0]!=0.
// - funct3 values 011/110/111 on a mem op are treated as W.
// - Byte enables:
//     B        -> 4'b0001 << addr[1:0]
//     H        -> 4'b0011 << addr[1:0]
//     W        -> 4'b1111
//     load     -> mbe is don't-care, driven as 4'b1111
// - FSM IDLE:
//     On mem_op, drive the request combinationally from the inputs in the same cycle.
//     Latch addr/funct3/data/rd/ctrl into request regs.
//     If dmem_resp==0: go to WAIT.
//     If dmem_resp==1: zero-wait completion; no stall, stay in IDLE.
// - FSM WAIT:
//     Request is driven from the latched regs and held stable until resp.
//     On dmem_resp: complete and go to IDLE.
//     Counter increments each WAIT cycle. At MAX_WAIT: set timeout_err and keep waiting.
// - stall = (IDLE & mem_op & ~dmem_resp) | (WAIT & ~dmem_resp).
//   stall is 0 in the resp cycle, so the pipeline advances at that edge.
// - MEM/WB regs update only on edges where stall==0:
//     wb_valid        <= in_valid
//     wb_rd           <= in_rd
//     wb_load_regfile <= in_valid & in_load_regfile & ~misaligned & (in_rd!=0)
//     wb_data         <= in_is_load ? aligned load : in_alu_data
// - Load align: shift = dmem_rdata >> 8*addr[1:0].
//     B/H sign-extend from bit 7/15. BU/HU zero-extend. W passes through.
// - Misaligned mem op:
//     No request issued, no stall.
//     misaligned_err=1 for the cycle after the edge where it enters MEM/WB.
//     wb_valid=1, wb_load_regfile=0.
// - Reset mid-WAIT: request dropped at the next edge. A late dmem_resp in IDLE with no mem_op is ignored.
// - Back-to-back mem ops: the second op's request appears in the cycle after the first resp; no bubble cycle.
// TESTING
// 1. LW addr 0x100, resp after 3 cycles with rdata 0xDEADBEEF
//      -> dmem_read=1 for 3 cycles, stall=1 for 2 cycles, wb_data=0xDEADBEEF
// 2. LB addr 0x203, rdata 0x80123456  -> wb_data=0xFFFFFF80
//    LBU at the same addr             -> wb_data=0x00000080
// 3. SH addr 0x102, store_data 0xBEEF0000
//      -> dmem_write=1, mbe=4'b1100, dmem_address=0x100, wb_load_regfile=0
// 4. LW addr 0x101
//      -> no dmem_read, stall=0, misaligned_err pulse, wb_load_regfile=0
// 5. Same-cycle resp: LW with dmem_resp=1 in the issue cycle -> stall never 1, wb_data=rdata next cycle
//    Reset asserted during WAIT        -> dmem_read=0 next cycle, state IDLE
// 6. MAX_WAIT=4, no resp              -> timeout_err=1 after 4 WAIT cycles, stays 1
//    Later resp                        -> completes normally

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the rv32i pipeline, between EX/MEM and MEM/WB.
//   - Issues load/store requests to the data cache (read/write/resp handshake)
//     and generates byte enables.
//   - Aligns and sign/zero-extends load data.
//   - Stalls the pipeline while a request is outstanding.
//   - Registers the MEM/WB result.
//
// Ports:
//   clk, rst (sync, active-low)
//   in_*            EX/MEM entry (valid, load/store, funct3, addr, data, rd, regfile enable)
//   dmem_*          data cache request/response
//   stall           freeze upstream pipeline registers this cycle
//   wb_*            MEM/WB entry (also the mem_wb forwarding source)
//   misaligned_err  one-cycle pulse when a misaligned access was dropped
//   timeout_err     sticky flag, set after MAX_WAIT cycles in WAIT
//   dbg_state       current FSM state (0 = IDLE, 1 = WAIT)
//
// Handshake: a request is live while dmem_read or dmem_write is 1. Address,
// data and byte enables are held stable until the cycle in which dmem_resp
// pulses; that cycle completes the request (possibly the issue cycle itself).
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_alu_data,
  input  logic [4:0]  in_rd,
  input  logic        in_load_regfile,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_load_regfile,
  output logic [31:0] wb_data,
  output logic        misaligned_err,
  output logic        timeout_err,
  output logic        dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [2:0]  req_funct3_q, req_funct3_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic        req_is_load_q, req_is_load_d;
  logic        req_is_store_q, req_is_store_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_lrf_q, wb_lrf_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mis_err_q, mis_err_d;

  logic        is_mem, misaligned, mem_op, waiting, req_live;
  logic [31:0] cur_addr, cur_wdata, shifted, aligned;
  logic [2:0]  cur_funct3;
  logic        cur_is_load, cur_is_store;

  always_comb begin
    is_mem     = in_valid & (in_is_load | in_is_store);
    // funct3[1]==1 covers W and the 011/110/111 encodings treated as W.
    misaligned = is_mem & (((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                           (in_funct3[1] & (in_addr[1:0] != 2'b00)));
    mem_op     = is_mem & ~misaligned;
    waiting    = (state_q == S_WAIT);

    // In WAIT the request comes from the latched copy so it stays stable.
    cur_addr     = waiting ? req_addr_q     : in_addr;
    cur_funct3   = waiting ? req_funct3_q   : in_funct3;
    cur_wdata    = waiting ? req_wdata_q    : in_store_data;
    cur_is_load  = waiting ? req_is_load_q  : in_is_load;
    cur_is_store = waiting ? req_is_store_q : in_is_store;

    req_live     = rst & (waiting | mem_op);
    dmem_read    = req_live & cur_is_load;
    dmem_write   = req_live & cur_is_store;
    dmem_address = {cur_addr[31:2], 2'b00};
    dmem_wdata   = cur_wdata;

    dmem_mbe = 4'b1111;
    if (!cur_is_load) begin
      case (cur_funct3[1:0])
        2'b00:   dmem_mbe = 4'b0001 << cur_addr[1:0];
        2'b01:   dmem_mbe = 4'b0011 << cur_addr[1:0];
        default: dmem_mbe = 4'b1111;
      endcase
    end

    stall = rst & ((~waiting & mem_op & ~dmem_resp) | (waiting & ~dmem_resp));

    shifted = dmem_rdata >> {cur_addr[1:0], 3'b000};
    case (cur_funct3)
      3'b000:  aligned = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  aligned = {24'h0, shifted[7:0]};
      3'b001:  aligned = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  aligned = {16'h0, shifted[15:0]};
      default: aligned = shifted;
    endcase

    state_d        = state_q;
    req_addr_d     = req_addr_q;
    req_funct3_d   = req_funct3_q;
    req_wdata_d    = req_wdata_q;
    req_is_load_d  = req_is_load_q;
    req_is_store_d = req_is_store_q;
    wait_cnt_d     = 16'd0;
    timeout_d      = timeout_q;

    if (!waiting) begin
      if (mem_op) begin
        req_addr_d     = in_addr;
        req_funct3_d   = in_funct3;
        req_wdata_d    = in_store_data;
        req_is_load_d  = in_is_load;
        req_is_store_d = in_is_store;
        if (!dmem_resp) state_d = S_WAIT;
      end
    end else if (dmem_resp) begin
      state_d = S_IDLE;
    end else begin
      // Count saturates at MAX_WAIT; the error stays set and we keep waiting.
      wait_cnt_d = (32'(wait_cnt_q) >= MAX_WAIT) ? wait_cnt_q : wait_cnt_q + 16'd1;
      if (32'(wait_cnt_q) + 32'd1 == MAX_WAIT) timeout_d = 1'b1;
    end

    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_lrf_d   = wb_lrf_q;
    wb_data_d  = wb_data_q;
    if (!stall) begin
      wb_valid_d = in_valid;
      wb_rd_d    = in_rd;
      wb_lrf_d   = in_valid & in_load_regfile & ~misaligned & (in_rd != 5'd0);
      wb_data_d  = in_is_load ? aligned : in_alu_data;
    end
    mis_err_d = ~stall & misaligned;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      req_addr_q     <= 32'h0;
      req_funct3_q   <= 3'h0;
      req_wdata_q    <= 32'h0;
      req_is_load_q  <= 1'b0;
      req_is_store_q <= 1'b0;
      wait_cnt_q     <= 16'd0;
      timeout_q      <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_lrf_q       <= 1'b0;
      wb_data_q      <= 32'h0;
      mis_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      req_funct3_q   <= req_funct3_d;
      req_wdata_q    <= req_wdata_d;
      req_is_load_q  <= req_is_load_d;
      req_is_store_q <= req_is_store_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_q      <= timeout_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_lrf_q       <= wb_lrf_d;
      wb_data_q      <= wb_data_d;
      mis_err_q      <= mis_err_d;
    end
  end

  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_load_regfile = wb_lrf_q;
  assign wb_data         = wb_data_q;
  assign misaligned_err  = mis_err_q;
  assign timeout_err     = timeout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (MAX_WAIT = 4).
// Inputs change 1 time unit after posedge; combinational outputs are checked
// 3 units later, registered outputs 1 unit after the next posedge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_is_load, in_is_store, in_load_regfile;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_store_data, in_alu_data, dmem_rdata;
  logic [4:0]  in_rd;
  logic        dmem_resp;
  logic        dmem_read, dmem_write, stall, wb_valid, wb_load_regfile;
  logic        misaligned_err, timeout_err, dbg_state;
  logic [31:0] dmem_address, dmem_wdata, wb_data;
  logic [3:0]  dmem_mbe;
  logic [4:0]  wb_rd;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data),
    .in_alu_data(in_alu_data), .in_rd(in_rd), .in_load_regfile(in_load_regfile),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_load_regfile(wb_load_regfile), .wb_data(wb_data),
    .misaligned_err(misaligned_err), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000;
    in_addr = 32'h0; in_store_data = 32'h0; in_alu_data = 32'h0; in_rd = 5'd0;
    in_load_regfile = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = f3;
    in_addr = addr; in_store_data = 32'h0; in_alu_data = 32'h5555_5555;
    in_rd = rd; in_load_regfile = 1'b1;
  endtask

  task automatic drive_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd);
    in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b1; in_funct3 = f3;
    in_addr = addr; in_store_data = sd; in_alu_data = 32'hA5A5_0000;
    in_rd = 5'd0; in_load_regfile = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (3) next_cycle();
    settle();
    n_cmp++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL reset_comb got rd=%b wr=%b st=%b exp 0/0/0", dmem_read, dmem_write, stall); end
    n_cmp++; if ({wb_valid, wb_load_regfile, misaligned_err, timeout_err, dbg_state} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b exp 00000", {wb_valid, wb_load_regfile, misaligned_err, timeout_err, dbg_state}); end
    n_cmp++; if (wb_data !== 32'h0 || wb_rd !== 5'd0) begin n_err++; $display("FAIL reset_wb got data=%h rd=%0d exp 0/0", wb_data, wb_rd); end
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_lw_wait();
    int reads = 0;
    int stalls = 0;
    drive_load(3'b010, 32'h100, 5'd5);
    for (int i = 0; i < 3; i++) begin
      dmem_resp  = (i == 2);
      dmem_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
      settle();
      if (dmem_read === 1'b1) reads++;
      if (stall === 1'b1) stalls++;
      n_cmp++; if (dmem_address !== 32'h100 || dmem_mbe !== 4'b1111) begin n_err++; $display("FAIL lw_req cyc=%0d got addr=%h mbe=%b exp 00000100/1111", i, dmem_address, dmem_mbe); end
      next_cycle();
    end
    n_cmp++; if (reads !== 3) begin n_err++; $display("FAIL lw_read_cycles got %0d exp 3", reads); end
    n_cmp++; if (stalls !== 2) begin n_err++; $display("FAIL lw_stall_cycles got %0d exp 2", stalls); end
    n_cmp++; if (wb_data !== 32'hDEAD_BEEF || wb_valid !== 1'b1 || wb_load_regfile !== 1'b1 || wb_rd !== 5'd5) begin n_err++; $display("FAIL lw_wb got data=%h v=%b lrf=%b rd=%0d exp deadbeef/1/1/5", wb_data, wb_valid, wb_load_regfile, wb_rd); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL lw_state got %b exp 0", dbg_state); end
    drive_idle();
  endtask

  task automatic test_load_align();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h203, 32'h203, 32'h202, 32'h202};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_8012};
    for (int i = 0; i < 4; i++) begin
      drive_load(f3s[i], adrs[i], 5'd7);
      dmem_resp = 1'b1; dmem_rdata = 32'h8012_3456;
      settle();
      n_cmp++; if (stall !== 1'b0 || dmem_read !== 1'b1) begin n_err++; $display("FAIL align_req idx=%0d got st=%b rd=%b exp 0/1", i, stall, dmem_read); end
      next_cycle();
      n_cmp++; if (wb_data !== exps[i]) begin n_err++; $display("FAIL align_data idx=%0d got %h exp %h", i, wb_data, exps[i]); end
    end
    drive_idle();
  endtask

  task automatic test_store();
    drive_store(3'b001, 32'h102, 32'hBEEF_0000);
    settle();
    n_cmp++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || stall !== 1'b1) begin n_err++; $display("FAIL sh_issue got wr=%b rd=%b st=%b exp 1/0/1", dmem_write, dmem_read, stall); end
    n_cmp++; if (dmem_mbe !== 4'b1100 || dmem_address !== 32'h100 || dmem_wdata !== 32'hBEEF_0000) begin n_err++; $display("FAIL sh_fields got mbe=%b addr=%h wd=%h exp 1100/00000100/beef0000", dmem_mbe, dmem_address, dmem_wdata); end
    next_cycle();
    dmem_resp = 1'b1;
    settle();
    n_cmp++; if (dmem_write !== 1'b1 || dmem_mbe !== 4'b1100 || dmem_address !== 32'h100 || stall !== 1'b0) begin n_err++; $display("FAIL sh_hold got wr=%b mbe=%b addr=%h st=%b exp 1/1100/00000100/0", dmem_write, dmem_mbe, dmem_address, stall); end
    next_cycle();
    n_cmp++; if (wb_load_regfile !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'hA5A5_0000) begin n_err++; $display("FAIL sh_wb got lrf=%b v=%b data=%h exp 0/1/a5a50000", wb_load_regfile, wb_valid, wb_data); end
    drive_store(3'b000, 32'h101, 32'h0000_AB00);
    dmem_resp = 1'b1;
    settle();
    n_cmp++; if (dmem_mbe !== 4'b0010 || dmem_write !== 1'b1) begin n_err++; $display("FAIL sb_mbe got mbe=%b wr=%b exp 0010/1", dmem_mbe, dmem_write); end
    next_cycle();
    drive_store(3'b010, 32'h104, 32'h1234_5678);
    dmem_resp = 1'b1;
    settle();
    n_cmp++; if (dmem_mbe !== 4'b1111 || dmem_address !== 32'h104) begin n_err++; $display("FAIL sw_mbe got mbe=%b addr=%h exp 1111/00000104", dmem_mbe, dmem_address); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_misaligned();
    drive_load(3'b010, 32'h101, 5'd3);
    settle();
    n_cmp++; if (dmem_read !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL mis_lw_req got rd=%b st=%b exp 0/0", dmem_read, stall); end
    next_cycle();
    n_cmp++; if (misaligned_err !== 1'b1 || wb_valid !== 1'b1 || wb_load_regfile !== 1'b0) begin n_err++; $display("FAIL mis_lw_wb got err=%b v=%b lrf=%b exp 1/1/0", misaligned_err, wb_valid, wb_load_regfile); end
    drive_store(3'b001, 32'h201, 32'h0);
    settle();
    n_cmp++; if (dmem_write !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL mis_sh_req got wr=%b st=%b exp 0/0", dmem_write, stall); end
    next_cycle();
    drive_idle();
    n_cmp++; if (misaligned_err !== 1'b1) begin n_err++; $display("FAIL mis_sh_err got %b exp 1", misaligned_err); end
    next_cycle();
    n_cmp++; if (misaligned_err !== 1'b0) begin n_err++; $display("FAIL mis_pulse_end got %b exp 0", misaligned_err); end
  endtask

  task automatic test_zero_wait();
    drive_load(3'b010, 32'h300, 5'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    settle();
    n_cmp++; if (stall !== 1'b0 || dmem_read !== 1'b1) begin n_err++; $display("FAIL zw_issue got st=%b rd=%b exp 0/1", stall, dmem_read); end
    next_cycle();
    n_cmp++; if (wb_data !== 32'hCAFE_F00D || dbg_state !== 1'b0) begin n_err++; $display("FAIL zw_wb got data=%h state=%b exp cafef00d/0", wb_data, dbg_state); end
    n_cmp++; if (wb_load_regfile !== 1'b0) begin n_err++; $display("FAIL zw_rd0_lrf got %b exp 0", wb_load_regfile); end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    drive_load(3'b010, 32'h10, 5'd1);
    next_cycle();
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
    next_cycle();
    n_cmp++; if (wb_data !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_first got %h exp 11111111", wb_data); end
    drive_load(3'b010, 32'h20, 5'd2);
    dmem_resp = 1'b0;
    settle();
    n_cmp++; if (dmem_read !== 1'b1 || dmem_address !== 32'h20 || stall !== 1'b1) begin n_err++; $display("FAIL b2b_second got rd=%b addr=%h st=%b exp 1/00000020/1", dmem_read, dmem_address, stall); end
    next_cycle();
    dmem_resp = 1'b1; dmem_rdata = 32'h2222_2222;
    next_cycle();
    n_cmp++; if (wb_data !== 32'h2222_2222 || wb_rd !== 5'd2) begin n_err++; $display("FAIL b2b_second_wb got data=%h rd=%0d exp 22222222/2", wb_data, wb_rd); end
    drive_idle();
  endtask

  task automatic test_reset_mid_wait();
    drive_load(3'b010, 32'h400, 5'd4);
    next_cycle();
    n_cmp++; if (dbg_state !== 1'b1) begin n_err++; $display("FAIL rmw_enter got state=%b exp 1", dbg_state); end
    rst = 1'b0;
    drive_idle();
    next_cycle();
    rst = 1'b1;
    settle();
    n_cmp++; if (dmem_read !== 1'b0 || dbg_state !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL rmw_drop got rd=%b state=%b st=%b exp 0/0/0", dmem_read, dbg_state, stall); end
    dmem_resp = 1'b1; dmem_rdata = 32'h9999_9999;
    settle();
    n_cmp++; if (dmem_read !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL late_resp got rd=%b st=%b exp 0/0", dmem_read, stall); end
    next_cycle();
    n_cmp++; if (wb_valid !== 1'b0 || dbg_state !== 1'b0) begin n_err++; $display("FAIL late_resp_wb got v=%b state=%b exp 0/0", wb_valid, dbg_state); end
    drive_idle();
  endtask

  task automatic test_timeout();
    drive_load(3'b010, 32'h40, 5'd9);
    next_cycle();
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      n_cmp++; if (timeout_err !== (i >= 4) || stall !== 1'b1) begin n_err++; $display("FAIL timeout wait=%0d got to=%b st=%b exp %b/1", i, timeout_err, stall, (i >= 4)); end
    end
    dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
    settle();
    n_cmp++; if (stall !== 1'b0 || dmem_read !== 1'b1) begin n_err++; $display("FAIL timeout_resp got st=%b rd=%b exp 0/1", stall, dmem_read); end
    next_cycle();
    drive_idle();
    n_cmp++; if (wb_data !== 32'h1234_5678 || timeout_err !== 1'b1 || dbg_state !== 1'b0) begin n_err++; $display("FAIL timeout_done got data=%h to=%b state=%b exp 12345678/1/0", wb_data, timeout_err, dbg_state); end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_load_align();
    test_store();
    test_misaligned();
    test_zero_wait();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
